window_3x3_gen: RTL and testbench

Streaming 3x3 neighbourhood generator that sits directly upstream of the 3x3 convolution kernels (emboss, blur, edge) in the 256x256 pipeline. It accepts a raster-order pixel stream, buffers the two previous image rows, and presents a registered 3x3 window on `p0..p8` with a valid strobe. The kernel consumes the window combinationally in the same cycle. Only interior centres are emitted: no padding, and each frame yields (IMG_W-2)x(IMG_H-2) windows.

---
 rtl/window_3x3_gen_pkg.sv | 17 +
 rtl/window_3x3_gen_line_buffer.sv | 39 +++
 rtl/window_3x3_gen.sv | 124 ++++++++++++
 tb/tb_window_3x3_gen.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/window_3x3_gen_pkg.sv
// -----------------------------------------------------------------------------
// window_3x3_gen_pkg
// Shared defaults for the 3x3 window generator and its line buffers:
// image geometry, pixel width and a helper that sizes the position counters.
// -----------------------------------------------------------------------------
package window_3x3_gen_pkg;

   localparam int DEF_IMG_W = 256;   // pixels per row
   localparam int DEF_IMG_H = 256;   // rows per frame
   localparam int DEF_PIX_W = 17;    // pixel width seen by the 3x3 kernels

   // Bits needed to count 0..n-1; never less than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/window_3x3_gen_line_buffer.sv
// -----------------------------------------------------------------------------
// line_buffer
// One image row of storage. A single address serves both the synchronous write
// port and the asynchronous read port, so a read in the same cycle as a write
// to that address returns the data stored before the write.
//
// Ports
//   clk    in  rising-edge clock
//   we     in  write enable
//   addr   in  column index, shared by read and write
//   wdata  in  data written at addr on a clock edge with we high
//   rdata  out current contents at addr (pre-write value)
// -----------------------------------------------------------------------------
module line_buffer
   import window_3x3_gen_pkg::*;
#(
   parameter int DEPTH = DEF_IMG_W,
   parameter int WIDTH = DEF_PIX_W
) (
   input  logic                       clk,
   input  logic                       we,
   input  logic [cnt_w(DEPTH)-1:0]    addr,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: the storage array has no reset; rows 0 and 1 of every frame refill
   // both buffers before any window built from them is flagged valid.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/window_3x3_gen.sv
// -----------------------------------------------------------------------------
// window_3x3_gen
// Streaming 3x3 neighbourhood generator. Takes a raster-order pixel stream,
// keeps the two previous rows in line buffers and presents a registered 3x3
// window with a valid strobe. Only interior centres are flagged valid, so a
// frame yields (IMG_W-2)*(IMG_H-2) windows.
//
// Ports
//   clk        in  rising-edge clock
//   reset      in  synchronous, active-high; wins over pix_valid
//   pix_in     in  raster pixel, top-left first
//   pix_valid  in  pix_in is accepted on an edge where this is high
//   p0..p2     out window top row, left to right
//   p3..p5     out window middle row (p4 is the centre)
//   p6..p8     out window bottom row
//   win_valid  out one-cycle pulse: p0..p8 hold a complete interior window
//   win_last   out with win_valid, marks the last window of the frame
// -----------------------------------------------------------------------------
module window_3x3_gen
   import window_3x3_gen_pkg::*;
#(
   parameter int IMG_W = DEF_IMG_W,
   parameter int IMG_H = DEF_IMG_H,
   parameter int PIX_W = DEF_PIX_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [PIX_W-1:0] pix_in,
   input  logic             pix_valid,
   output logic [PIX_W-1:0] p0,
   output logic [PIX_W-1:0] p1,
   output logic [PIX_W-1:0] p2,
   output logic [PIX_W-1:0] p3,
   output logic [PIX_W-1:0] p4,
   output logic [PIX_W-1:0] p5,
   output logic [PIX_W-1:0] p6,
   output logic [PIX_W-1:0] p7,
   output logic [PIX_W-1:0] p8,
   output logic             win_valid,
   output logic             win_last
);

   localparam int COL_W = cnt_w(IMG_W);
   localparam int ROW_W = cnt_w(IMG_H);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
   localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
   localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic [PIX_W-1:0] lb0_q;   // row r-1 at this column
   logic [PIX_W-1:0] lb1_q;   // row r-2 at this column
   logic             lb_we;

   // Buffers only move on accepted pixels; a reset edge accepts nothing.
   assign lb_we = pix_valid & ~reset;

   // lb0 takes the incoming pixel; lb1 takes what lb0 held, so the row
   // shuffle r-1 -> r-2 happens column by column as the stream passes.
   line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) lb0 (
      .clk   (clk),
      .we    (lb_we),
      .addr  (col),
      .wdata (pix_in),
      .rdata (lb0_q)
   );

   line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) lb1 (
      .clk   (clk),
      .we    (lb_we),
      .addr  (col),
      .wdata (lb0_q),
      .rdata (lb1_q)
   );

   // NOTE: every register here uses non-blocking assignment so the window
   // shift (p1 -> p0, p2 -> p1) samples the old values, not this edge's.
   always_ff @(posedge clk) begin
      if (reset) begin
         col       <= '0;
         row       <= '0;
         p0        <= '0;
         p1        <= '0;
         p2        <= '0;
         p3        <= '0;
         p4        <= '0;
         p5        <= '0;
         p6        <= '0;
         p7        <= '0;
         p8        <= '0;
         win_valid <= 1'b0;
         win_last  <= 1'b0;
      end else begin
         win_valid <= 1'b0;
         win_last  <= 1'b0;
         if (pix_valid) begin
            // Shift the window left; the new right column is rows r-2, r-1, r.
            p0 <= p1;
            p1 <= p2;
            p2 <= lb1_q;
            p3 <= p4;
            p4 <= p5;
            p5 <= lb0_q;
            p6 <= p7;
            p7 <= p8;
            p8 <= pix_in;

            // Columns 0 and 1 still carry the previous row's right edge.
            win_valid <= (row >= ROW_TWO) && (col >= COL_TWO);
            win_last  <= (row == ROW_LAST) && (col == COL_LAST);

            if (col == COL_LAST) begin
               col <= '0;
               row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_window_3x3_gen.sv
// -----------------------------------------------------------------------------
// tb_window_3x3_gen
// Self-checking bench. A reduced 8x6 instance exercises the ramp frame,
// random gaps, mid-frame reset and back-to-back frames; a 4x3 instance covers
// the smallest geometry. Pixel values follow base + row*256 + col.
// -----------------------------------------------------------------------------
module tb_window_3x3_gen;

   localparam int W     = 8;
   localparam int H     = 6;
   localparam int PIX_W = 17;
   localparam int SW    = 4;
   localparam int SH    = 3;

   logic             clk = 1'b0;
   logic             reset;
   logic [PIX_W-1:0] pix_in;
   logic             pix_valid;
   logic [PIX_W-1:0] p [9];
   logic             win_valid;
   logic             win_last;

   logic [PIX_W-1:0] s_pix;
   logic             s_valid;
   logic [PIX_W-1:0] sp [9];
   logic             s_win_valid;
   logic             s_win_last;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   window_3x3_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(PIX_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .pix_in    (pix_in),
      .pix_valid (pix_valid),
      .p0 (p[0]), .p1 (p[1]), .p2 (p[2]),
      .p3 (p[3]), .p4 (p[4]), .p5 (p[5]),
      .p6 (p[6]), .p7 (p[7]), .p8 (p[8]),
      .win_valid (win_valid),
      .win_last  (win_last)
   );

   window_3x3_gen #(.IMG_W(SW), .IMG_H(SH), .PIX_W(PIX_W)) dut_s (
      .clk       (clk),
      .reset     (reset),
      .pix_in    (s_pix),
      .pix_valid (s_valid),
      .p0 (sp[0]), .p1 (sp[1]), .p2 (sp[2]),
      .p3 (sp[3]), .p4 (sp[4]), .p5 (sp[5]),
      .p6 (sp[6]), .p7 (sp[7]), .p8 (sp[8]),
      .win_valid (s_win_valid),
      .win_last  (s_win_last)
   );

   typedef struct {
      int               r;
      int               c;
      logic             v;
      logic             last;
      logic [PIX_W-1:0] e0;
      logic [PIX_W-1:0] e4;
      logic [PIX_W-1:0] e8;
   } vec_t;

   vec_t tbl [6];

   function automatic logic [PIX_W-1:0] pix(input int base, input int r, input int c);
      return PIX_W'(base + r * 256 + c);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Present one input for one rising edge, then sample 1 time unit after it.
   task automatic push(input logic v, input logic [PIX_W-1:0] d);
      pix_valid = v;
      pix_in    = d;
      @(posedge clk);
      #1;
   endtask

   // Streams one frame and checks every output against the ramp model.
   task automatic run_frame(input int base, input int gap_pct, output int n_win);
      logic exp_v;
      n_win = 0;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            if (gap_pct > 0) begin
               for (int g = 0; g < 10 && $urandom_range(99) < gap_pct; g++) begin
                  push(1'b0, 17'h1abcd);
                  check("gap_valid", 32'(win_valid), 32'd0);
               end
            end
            push(1'b1, pix(base, r, c));
            exp_v = (r >= 2) && (c >= 2);
            check("win_valid", 32'(win_valid), 32'(exp_v));
            if (exp_v) begin
               n_win++;
               for (int i = 0; i < 9; i++) begin
                  check($sformatf("p%0d@(%0d,%0d)", i, r, c), 32'(p[i]),
                        32'(pix(base, r - 2 + i / 3, c - 2 + i % 3)));
               end
               check("win_last", 32'(win_last), 32'((r == H - 1) && (c == W - 1)));
            end
         end
      end
      pix_valid = 1'b0;
   endtask

   initial begin
      int k;
      int nwin;
      int nlast;
      int sn;

      // Checkpoints in the 8x6 ramp frame (base 0).
      tbl[0] = '{r: 2, c: 1, v: 1'b0, last: 1'b0, e0: 0,   e4: 0,    e8: 0};
      tbl[1] = '{r: 2, c: 2, v: 1'b1, last: 1'b0, e0: 0,   e4: 257,  e8: 514};
      tbl[2] = '{r: 3, c: 0, v: 1'b0, last: 1'b0, e0: 0,   e4: 0,    e8: 0};
      tbl[3] = '{r: 3, c: 2, v: 1'b1, last: 1'b0, e0: 256, e4: 513,  e8: 770};
      tbl[4] = '{r: 4, c: 5, v: 1'b1, last: 1'b0, e0: 515, e4: 772,  e8: 1029};
      tbl[5] = '{r: 5, c: 7, v: 1'b1, last: 1'b1, e0: 773, e4: 1030, e8: 1287};

      reset     = 1'b1;
      pix_valid = 1'b0;
      pix_in    = '0;
      s_valid   = 1'b0;
      s_pix     = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_p0", 32'(p[0]), 32'd0);
      check("rst_p4", 32'(p[4]), 32'd0);
      check("rst_p8", 32'(p[8]), 32'd0);
      check("rst_valid", 32'(win_valid), 32'd0);
      check("rst_last", 32'(win_last), 32'd0);
      reset = 1'b0;

      // Table-driven ramp frame at full rate.
      k = 0;
      nwin = 0;
      nlast = 0;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            push(1'b1, pix(0, r, c));
            if (win_valid) nwin++;
            if (win_valid && win_last) nlast++;
            if (k < 6 && tbl[k].r == r && tbl[k].c == c) begin
               check($sformatf("tbl%0d_valid", k), 32'(win_valid), 32'(tbl[k].v));
               check($sformatf("tbl%0d_last", k), 32'(win_last), 32'(tbl[k].last));
               if (tbl[k].v) begin
                  check($sformatf("tbl%0d_p0", k), 32'(p[0]), 32'(tbl[k].e0));
                  check($sformatf("tbl%0d_p4", k), 32'(p[4]), 32'(tbl[k].e4));
                  check($sformatf("tbl%0d_p8", k), 32'(p[8]), 32'(tbl[k].e8));
               end
               k++;
            end
         end
      end
      pix_valid = 1'b0;
      check("ramp_tbl_hits", 32'(k), 32'd6);
      check("ramp_win_count", 32'(nwin), 32'((W - 2) * (H - 2)));
      check("ramp_last_count", 32'(nlast), 32'd1);

      // Same frame with pix_valid low about 40% of cycles.
      run_frame(0, 40, nwin);
      check("gap_win_count", 32'(nwin), 32'((W - 2) * (H - 2)));

      // Mid-frame reset: stop after (3,4), reset with pix_valid high.
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < W && !(r == 3 && c > 4); c++) begin
            push(1'b1, pix(0, r, c));
         end
      end
      check("pre_reset_p4", 32'(p[4]), 32'(pix(0, 2, 3)));
      reset = 1'b1;
      push(1'b1, 17'h0f0f0);
      reset = 1'b0;
      check("mid_rst_p0", 32'(p[0]), 32'd0);
      check("mid_rst_p4", 32'(p[4]), 32'd0);
      check("mid_rst_p8", 32'(p[8]), 32'd0);
      check("mid_rst_valid", 32'(win_valid), 32'd0);
      pix_valid = 1'b0;

      // Restreamed ramp then ramp+1000 back to back, no idle cycle between.
      run_frame(0, 0, nwin);
      check("after_rst_win_count", 32'(nwin), 32'((W - 2) * (H - 2)));
      run_frame(1000, 0, nwin);
      check("b2b_win_count", 32'(nwin), 32'((W - 2) * (H - 2)));
      push(1'b0, '0);
      check("b2b_idle_valid", 32'(win_valid), 32'd0);

      // Smallest geometry: 4x3 gives two windows, the second marked last.
      sn = 0;
      for (int r = 0; r < SH; r++) begin
         for (int c = 0; c < SW; c++) begin
            s_valid = 1'b1;
            s_pix   = pix(0, r, c);
            @(posedge clk);
            #1;
            if (s_win_valid) sn++;
            check($sformatf("s_valid(%0d,%0d)", r, c), 32'(s_win_valid),
                  32'((r == 2) && (c >= 2)));
            if (r == 2 && c >= 2) begin
               check("s_last", 32'(s_win_last), 32'(c == 3));
               check("s_p0", 32'(sp[0]), 32'(pix(0, 0, c - 2)));
               check("s_p4", 32'(sp[4]), 32'(pix(0, 1, c - 1)));
               check("s_p8", 32'(sp[8]), 32'(pix(0, 2, c)));
            end
         end
      end
      s_valid = 1'b0;
      @(posedge clk);
      #1;
      check("s_idle_valid", 32'(s_win_valid), 32'd0);
      check("s_win_count", 32'(sn), 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
